serial_alu_seq: RTL and testbench

- Bit-serial add/subtract sequencer: the driving end of the 1-bit full add/sub cell's carry chain.
- Accepts two WIDTH-bit operands and an op select through a valid/ready handshake.
- Processes one bit per clock, LSB first, recirculating carry/borrow through a flip-flop.
- Returns result plus carry/borrow, zero and signed-overflow flags through a second valid/ready handshake.
- Used where area matters more than latency.

---
 rtl/serial_alu_seq.sv | 111 +++++++++++
 tb/tb_serial_alu_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial add/subtract sequencer, one operand bit per clock, LSB first.
// Carry/borrow recirculates through c_q; result and flags load only on the completion edge.
module serial_alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             op_sel,
    input  logic             carry_i,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_o,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sub_q, sub_d, c_q, c_d, carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;
    logic xb, yb, s, c_nx, last;

    always_comb begin
        xb = x_q[0];
        yb = y_q[0];
        s = xb ^ yb ^ c_q;
        c_nx = sub_q ? ((~xb & yb) | (~xb & c_q) | (yb & c_q)) : ((xb & yb) | (xb & c_q) | (yb & c_q));
        last = cnt_q == CNT_W'(WIDTH - 1);
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        sub_d = sub_q;
        c_d = c_q;
        result_d = result_q;
        carry_d = carry_q;
        zero_d = zero_q;
        ovf_d = ovf_q;
        case (state_q)
            IDLE: if (start_valid) begin
                x_d = op_x;
                y_d = op_y;
                sub_d = op_sel;
                c_d = carry_i;
                cnt_d = '0;
                state_d = RUN;
            end
            RUN: begin
                // operands shift right so bit i is always at position 0; MSB arrives last
                x_d = x_q >> 1;
                y_d = y_q >> 1;
                acc_d = {s, acc_q[WIDTH-1:1]};
                c_d = c_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = DONE;
                    result_d = acc_d;
                    carry_d = c_nx;
                    zero_d = acc_d == '0;
                    ovf_d = (sub_q ? (xb != yb) : (xb == yb)) & (s != xb);
                end
            end
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            sub_q <= 1'b0;
            c_q <= 1'b0;
            result_q <= '0;
            carry_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sub_q <= sub_d;
            c_q <= c_d;
            result_q <= result_d;
            carry_q <= carry_d;
            zero_q <= zero_d;
            ovf_q <= ovf_d;
        end
    end

    assign start_ready = state_q == IDLE;
    assign res_valid = state_q == DONE;
    assign busy = state_q != IDLE;
    assign result = result_q;
    assign carry_o = carry_q;
    assign zero = zero_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed and random operations against an integer-arithmetic reference model.
module tb_serial_alu_seq;
    localparam int WIDTH = 8;
    logic clk = 1'b0, reset = 1'b1, start_valid = 1'b0, op_sel = 1'b0, carry_i = 1'b0, res_ready = 1'b0;
    logic [WIDTH-1:0] op_x = '0, op_y = '0, result;
    logic start_ready, res_valid, carry_o, zero, ovf, busy;
    int n_cmp = 0, n_bad = 0;

    serial_alu_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .op_x(op_x), .op_y(op_y), .op_sel(op_sel), .carry_i(carry_i),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .carry_o(carry_o), .zero(zero), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int x, input int y, input bit sub, input bit cin,
                         output int r, output bit co, output bit z, output bit v);
        int sx, sy, full, sres;
        sx = x >= 128 ? x - 256 : x;
        sy = y >= 128 ? y - 256 : y;
        full = sub ? x - y - int'(cin) : x + y + int'(cin);
        sres = sub ? sx - sy - int'(cin) : sx + sy + int'(cin);
        r = full & 255;
        co = sub ? (full < 0) : (full > 255);
        z = r == 0;
        v = sres > 127 || sres < -128;
    endtask

    task automatic do_op(input int x, input int y, input bit sub, input bit cin, input int hold);
        int r, lat;
        bit co, z, v;
        model(x, y, sub, cin, r, co, z, v);
        @(negedge clk);
        check("start_ready", int'(start_ready), 1);
        op_x = WIDTH'(x);
        op_y = WIDTH'(y);
        op_sel = sub;
        carry_i = cin;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        op_x = WIDTH'($urandom);
        op_y = WIDTH'($urandom);
        op_sel = 1'($urandom);
        carry_i = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, WIDTH);
        check("result", int'(result), r);
        check("carry_o", int'(carry_o), int'(co));
        check("zero", int'(zero), int'(z));
        check("ovf", int'(ovf), int'(v));
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'($urandom);
            @(negedge clk);
            start_valid = 1'b0;
            check("hold_valid", int'(res_valid), 1);
            check("hold_ready", int'(start_ready), 0);
            check("hold_result", int'({carry_o, zero, ovf, result}), int'({co, z, v, WIDTH'(r)}));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_ready", int'(start_ready), 1);
        check("idle_busy", int'({busy, res_valid}), 0);
        check("idle_result", int'(result), r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", int'(start_ready), 1);
        check("rst_valid_busy", int'({res_valid, busy}), 0);
        check("rst_outs", int'({carry_o, zero, ovf, result}), 0);
        do_op(8'h3C, 8'h0F, 0, 0, 0);
        do_op(8'hFF, 8'h01, 0, 0, 0);
        do_op(8'h7F, 8'h01, 0, 0, 0);
        do_op(8'h10, 8'h20, 1, 0, 0);
        do_op(8'h80, 8'h01, 1, 0, 0);
        do_op(8'h01, 8'h01, 0, 1, 0);
        do_op(8'h05, 8'h02, 1, 1, 0);
        do_op(8'hA5, 8'h5A, 1, 0, 5);
        do_op(8'h00, 8'h00, 1, 1, 0);
        // reset on the 4th RUN cycle discards the operation
        @(negedge clk);
        op_x = 8'h12;
        op_y = 8'h34;
        op_sel = 1'b0;
        carry_i = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", int'(start_ready), 1);
        check("mid_rst_valid", int'({res_valid, busy}), 0);
        check("mid_rst_outs", int'({carry_o, zero, ovf, result}), 0);
        do_op(8'h3C, 8'h0F, 0, 0, 0);
        // reset beats a simultaneous request
        reset = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_start", int'({busy, start_ready}), 1);
        for (int k = 0; k < 60; k++)
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
